// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding and iteration constants for multdiv_unit
package multdiv_pkg;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
    localparam int DEFAULT_WIDTH = 32;
    localparam int R2_BITS = 1;
    localparam int R4_BITS = 2;
    localparam int ITERS_R2 = DEFAULT_WIDTH / R2_BITS;
    localparam int ITERS_R4 = DEFAULT_WIDTH / R4_BITS;
endpackage

// File: rtl/multdiv_addsub.sv
// multdiv_addsub: N-bit adder/subtractor shared by multiply accumulate and divide trial-subtract
// Ports: a_i, b_i operands; sub_i selects a_i - b_i; sum_o result (carry discarded).
module multdiv_addsub
    import multdiv_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH + 1
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o
);
    assign sum_o = sub_i ? a_i - b_i : a_i + b_i;
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (shift-add or radix-4 Booth) and restoring divide
// Ports: clock, ctrl_reset (sync, active-high); data_operandA/B two's-complement operands;
//        ctrl_MULT/ctrl_DIV one-cycle starts (MULT wins); data_result/data_exception valid
//        while data_resultRDY pulses and held afterwards; busy from the cycle after a start
//        through the ready cycle.
// Build option: define MULTDIV_RADIX4_EN for radix-4 Booth multiply (WIDTH/2 iterations).
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
`ifdef MULTDIV_RADIX4_EN
    localparam int AW = WIDTH + 2;
    localparam int MUL_IT = WIDTH / R4_BITS;
`else
    localparam int AW = WIDTH + 1;
    localparam int MUL_IT = WIDTH / R2_BITS;
`endif
    localparam int DIV_IT = WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [AW-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_q, neg_d, dz_q, dz_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic [AW-1:0]      add_a, add_b, add_s, shifted, mul_hi, step_hi;
    logic               add_sub, is_div, ge, last, mul_exc, div_exc;
    logic [WIDTH-1:0]   mul_lo, step_lo, quo, mul_res, div_res, a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
`ifdef MULTDIV_RADIX4_EN
    logic               x_q, x_d, step_x;
    logic [2:0]         dig;
    logic [AW-1:0]      a_ext;
`else
    logic [2*WIDTH-1:0] prod_mag;
`endif

    multdiv_addsub #(.N(AW)) u_addsub (
        .a_i   (add_a),
        .b_i   (add_b),
        .sub_i (add_sub),
        .sum_o (add_s)
    );

    // One iteration of whichever operation is running; the finished result is taken
    // straight from the post-iteration values so it is registered on the last edge.
    always_comb begin
        is_div  = state_q == S_DIV;
        shifted = {hi_q[AW-2:0], lo_q[WIDTH-1]};
`ifdef MULTDIV_RADIX4_EN
        // Booth digit {b[i+1], b[i], b[i-1]} selects 0, +-A or +-2A on the signed operands.
        dig     = {lo_q[1:0], x_q};
        a_ext   = {{2{op_q[WIDTH-1]}}, op_q};
        add_a   = is_div ? shifted : hi_q;
        add_b   = is_div ? AW'(op_q) : (dig[1] ^ dig[0]) ? a_ext :
                  (dig == 3'b011 || dig == 3'b100) ? a_ext << 1 : '0;
        add_sub = is_div | (dig[2] & ~(dig[1] & dig[0]));
        step_x  = lo_q[1];
        mul_hi  = {{2{add_s[AW-1]}}, add_s[AW-1:2]};
        mul_lo  = {add_s[1:0], lo_q[WIDTH-1:2]};
        prod    = {mul_hi[WIDTH-1:0], mul_lo};
`else
        add_a    = is_div ? shifted : hi_q;
        add_b    = is_div ? AW'(op_q) : lo_q[0] ? AW'(op_q) : '0;
        add_sub  = is_div;
        mul_hi   = AW'(add_s[AW-1:1]);
        mul_lo   = {add_s[0], lo_q[WIDTH-1:1]};
        prod_mag = {mul_hi[WIDTH-1:0], mul_lo};
        prod     = neg_q ? -prod_mag : prod_mag;
`endif
        ge      = ~add_s[AW-1];
        step_hi = is_div ? (ge ? add_s : shifted) : mul_hi;
        step_lo = is_div ? {lo_q[WIDTH-2:0], ge} : mul_lo;
        quo     = neg_q ? -step_lo : step_lo;
        mul_res = prod[WIDTH-1:0];
        mul_exc = ~(&prod[2*WIDTH-1:WIDTH-1] | ~|prod[2*WIDTH-1:WIDTH-1]);
        div_res = dz_q ? '0 : quo;
        // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
        div_exc = dz_q | (step_lo[WIDTH-1] & ~neg_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        res_d   = res_q;
        exc_d   = exc_q;
`ifdef MULTDIV_RADIX4_EN
        x_d     = x_q;
`endif
        a_mag   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        last    = cnt_q == CW'((is_div ? DIV_IT : MUL_IT) - 1);
        if (state_q == S_MUL || state_q == S_DIV) begin
            cnt_d = cnt_q + CW'(1);
            hi_d  = step_hi;
            lo_d  = step_lo;
`ifdef MULTDIV_RADIX4_EN
            x_d   = step_x;
`endif
            if (last) begin
                state_d = S_DONE;
                res_d   = is_div ? div_res : mul_res;
                exc_d   = is_div ? div_exc : mul_exc;
            end
        end else if (ctrl_MULT || ctrl_DIV) begin
            state_d = ctrl_MULT ? S_MUL : S_DIV;
            cnt_d   = '0;
            hi_d    = '0;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d    = ~|data_operandB;
`ifdef MULTDIV_RADIX4_EN
            op_d    = ctrl_MULT ? data_operandA : b_mag;
            lo_d    = ctrl_MULT ? data_operandB : a_mag;
            x_d     = 1'b0;
`else
            op_d    = ctrl_MULT ? a_mag : b_mag;
            lo_d    = ctrl_MULT ? b_mag : a_mag;
`endif
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
`ifdef MULTDIV_RADIX4_EN
            x_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
`ifdef MULTDIV_RADIX4_EN
            x_q     <= x_d;
`endif
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = state_q == S_DONE;
    assign busy           = state_q != S_IDLE;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: randomized and directed self-checking bench for multdiv_unit
module tb_multdiv_unit;
    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;
    int          n_tests = 0;
    int          n_fail = 0;
`ifdef MULTDIV_RADIX4_EN
    localparam int MUL_LAT = 17;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    bit          d_mul [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] d_a   [5] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
    logic [31:0] d_b   [5] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] d_r   [5] = '{32'hFFFF_FFD6, 32'h0, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0};
    logic        d_e   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Reference: exact 64-bit signed arithmetic, C-style truncating division.
    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = '0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = 32'($signed(a) / $signed(b));
            e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 300));
            2: return -32'($urandom_range(0, 300));
            default: case ($urandom_range(0, 4))
                0: return 32'h8000_0000;
                1: return 32'hFFFF_FFFF;
                2: return 32'h0;
                3: return 32'h1;
                default: return 32'h7FFF_FFFF;
            endcase
        endcase
    endfunction

    // Caller sits at a negedge; the start is held for exactly one cycle.
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = m;
        ctrl_DIV = d;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
    endtask

    // c0 is the cycle index (relative to the start cycle) of the current negedge.
    task automatic wait_rdy(input int c0, output int lat, output int bcnt,
                            output logic [31:0] r, output logic e);
        lat = 0;
        bcnt = 0;
        r = 'x;
        e = 1'bx;
        for (int c = c0; c <= 120; c++) begin
            if (busy) bcnt++;
            if (data_resultRDY) begin
                lat = c;
                r = data_result;
                e = data_exception;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b required 0/0/0/0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        ctrl_reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b rdy=%b required 0/0", busy, data_resultRDY);
        end
    endtask

    task automatic test_directed;
        int lat, bcnt, exp_lat;
        logic [31:0] r;
        logic e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            issue(d_mul[i], !d_mul[i], d_a[i], d_b[i]);
            wait_rdy(1, lat, bcnt, r, e);
            exp_lat = d_mul[i] ? MUL_LAT : DIV_LAT;
            n_tests++;
            if (lat !== exp_lat || bcnt !== exp_lat) begin
                n_fail++;
                $display("FAIL directed%0d_latency: lat=%0d busy=%0d required %0d", i, lat, bcnt, exp_lat);
            end
            n_tests++;
            if (r !== d_r[i] || e !== d_e[i]) begin
                n_fail++;
                $display("FAIL directed%0d_result: got %h exc %b required %h exc %b", i, r, e, d_r[i], d_e[i]);
            end
            if (i == 0) begin
                @(negedge clock);
                n_tests++;
                if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== 32'hFFFF_FFD6) begin
                    n_fail++;
                    $display("FAIL pulse_hold: rdy=%b busy=%b result=%h required 0/0/ffffffd6",
                             data_resultRDY, busy, data_result);
                end
            end
        end
    endtask

    task automatic test_random;
        int lat, bcnt;
        bit m;
        logic [31:0] a, b, r, er;
        logic e, ee;
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            model(m, a, b, er, ee);
            @(negedge clock);
            issue(m, !m, a, b);
            wait_rdy(1, lat, bcnt, r, e);
            n_tests++;
            if (lat !== (m ? MUL_LAT : DIV_LAT) || r !== er || e !== ee) begin
                n_fail++;
                $display("FAIL random_%s: a=%h b=%h got %h exc %b lat %0d required %h exc %b lat %0d",
                         m ? "mul" : "div", a, b, r, e, lat, er, ee, m ? MUL_LAT : DIV_LAT);
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat, bcnt;
        logic [31:0] r;
        logic e;
        @(negedge clock);
        issue(1'b1, 1'b1, 32'd6, 32'hFFFF_FFF9);
        repeat (5) @(negedge clock);
        issue(1'b0, 1'b1, 32'd100, 32'd3);
        wait_rdy(7, lat, bcnt, r, e);
        n_tests++;
        if (lat !== MUL_LAT || r !== 32'hFFFF_FFD6 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start: got %h exc %b lat %0d required ffffffd6 exc 0 lat %0d", r, e, lat, MUL_LAT);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        logic [31:0] r;
        logic e;
        @(negedge clock);
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        wait_rdy(1, lat, bcnt, r, e);
        n_tests++;
        if (lat !== MUL_LAT || r !== 32'hFFFF_FFD6) begin
            n_fail++;
            $display("FAIL b2b_first: got %h lat %0d required ffffffd6 lat %0d", r, lat, MUL_LAT);
        end
        issue(1'b1, 1'b0, 32'd3, 32'd3);
        n_tests++;
        if (busy !== 1'b1 || data_resultRDY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b rdy=%b required 1/0", busy, data_resultRDY);
        end
        wait_rdy(1, lat, bcnt, r, e);
        n_tests++;
        if (lat !== MUL_LAT || r !== 32'd9 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got %h exc %b lat %0d required 9 exc 0 lat %0d", r, e, lat, MUL_LAT);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt, seen;
        logic [31:0] r;
        logic e;
        @(negedge clock);
        issue(1'b1, 1'b0, 32'd12345, 32'd678);
        repeat (9) @(negedge clock);
        ctrl_reset = 1'b1;
        @(negedge clock);
        ctrl_reset = 1'b0;
        n_tests++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h/%b/%b/%b required 0/0/0/0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY || busy) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: active cycles %0d required 0", seen);
        end
        issue(1'b0, 1'b1, 32'd100, 32'd10);
        wait_rdy(1, lat, bcnt, r, e);
        n_tests++;
        if (lat !== DIV_LAT || r !== 32'd10 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_div: got %h exc %b lat %0d required a exc 0 lat %0d", r, e, lat, DIV_LAT);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
